ball_motion: RTL

- Vertical-motion engine for the player ball in the game datapath.
- Produces ball height, instantaneous `ball_speed` and `direction` (1 = rising, 0 = falling).
- The speed/difficulty controller samples these outputs and returns `max_speed`. This block uses `max_speed` as the jump launch speed and the fall-speed cap.
- Position updates once per frame tick. Jumps come from the debounced player button.

---
 rtl/ball_motion.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ball_motion.sv
// ball_motion: vertical ball motion engine (launch, rise, apex, fall, floor/ceiling contact)
module ball_motion #(
  parameter int Y_W    = 9,
  parameter int Y_MAX  = 400,
  parameter int Y_INIT = 200
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           start,
  input  logic           collision,
  input  logic           jump,
  input  logic [3:0]     max_speed,
  output logic [Y_W-1:0] ball_y,
  output logic [3:0]     ball_speed,
  output logic           direction,
  output logic           alive,
  output logic           apex,
  output logic           hit_floor,
  output logic           hit_ceiling
);
  localparam logic [1:0] IDLE = 2'd0, RISE = 2'd1, FALL = 2'd2, DEAD = 2'd3;
  localparam logic [Y_W:0]   Y_TOP   = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W-1:0] Y_CEIL  = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] Y_START = Y_W'(Y_INIT);
  logic [1:0]     state_q, state_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [3:0]     speed_q, speed_d;
  logic           dir_q, dir_d;
  logic           apex_q, apex_d;
  logic           hit_floor_q, hit_floor_d;
  logic           hit_ceiling_q, hit_ceiling_d;
  logic           jump_q;
  logic           pend_q, pend_d;
  logic           pend_now;
  logic [3:0]     eff_max;
  logic [Y_W-1:0] speed_ext;
  logic [Y_W:0]   y_sum;
  logic [4:0]     spd_inc;
  assign pend_now  = pend_q | (jump & ~jump_q);
  assign eff_max   = (max_speed == 4'd0) ? 4'd1 : max_speed;
  assign speed_ext = {{(Y_W-4){1'b0}}, speed_q};
  assign y_sum     = {1'b0, y_q} + {1'b0, speed_ext};
  assign spd_inc   = {1'b0, speed_q} + 5'd1;
  always_comb begin
    state_d       = state_q;
    y_d           = y_q;
    speed_d       = speed_q;
    dir_d         = dir_q;
    apex_d        = 1'b0;
    hit_floor_d   = 1'b0;
    hit_ceiling_d = 1'b0;
    pend_d        = frame_tick ? 1'b0 : pend_now;
    if (!start) begin
      state_d = IDLE;
      y_d     = Y_START;
      speed_d = 4'd0;
      dir_d   = 1'b0;
    end else if (collision && (state_q == RISE || state_q == FALL)) begin
      state_d = DEAD;
      speed_d = 4'd0;
    end else if (frame_tick) begin
      if (state_q == IDLE) begin
        y_d     = Y_START;
        speed_d = pend_now ? eff_max : 4'd0;
        dir_d   = pend_now;
        state_d = pend_now ? RISE : IDLE;
      end else if (state_q == RISE) begin
        if (pend_now) begin
          speed_d = eff_max;
          dir_d   = 1'b1;
        end else if (y_sum >= Y_TOP) begin
          y_d           = Y_CEIL;
          speed_d       = 4'd0;
          dir_d         = 1'b0;
          hit_ceiling_d = 1'b1;
          state_d       = FALL;
        end else begin
          y_d     = y_sum[Y_W-1:0];
          speed_d = (speed_q == 4'd0) ? 4'd0 : speed_q - 4'd1;
          // Speed about to reach zero: this is the apex, hand over to FALL.
          if (speed_q <= 4'd1) begin
            dir_d   = 1'b0;
            apex_d  = 1'b1;
            state_d = FALL;
          end
        end
      end else if (state_q == FALL) begin
        if (pend_now) begin
          speed_d = eff_max;
          dir_d   = 1'b1;
          state_d = RISE;
        end else if (y_q <= speed_ext && speed_q != 4'd0) begin
          y_d         = '0;
          speed_d     = 4'd0;
          hit_floor_d = 1'b1;
          state_d     = DEAD;
        end else begin
          y_d     = y_q - speed_ext;
          speed_d = (spd_inc > {1'b0, eff_max}) ? eff_max : spd_inc[3:0];
        end
      end else begin
        speed_d = 4'd0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      y_q           <= Y_START;
      speed_q       <= 4'd0;
      dir_q         <= 1'b0;
      apex_q        <= 1'b0;
      hit_floor_q   <= 1'b0;
      hit_ceiling_q <= 1'b0;
      jump_q        <= 1'b0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      y_q           <= y_d;
      speed_q       <= speed_d;
      dir_q         <= dir_d;
      apex_q        <= apex_d;
      hit_floor_q   <= hit_floor_d;
      hit_ceiling_q <= hit_ceiling_d;
      jump_q        <= jump;
      pend_q        <= pend_d;
    end
  end
  assign ball_y      = y_q;
  assign ball_speed  = speed_q;
  assign direction   = dir_q;
  assign alive       = (state_q == RISE) || (state_q == FALL);
  assign apex        = apex_q;
  assign hit_floor   = hit_floor_q;
  assign hit_ceiling = hit_ceiling_q;
endmodule
